// File: rtl/intack_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
package intack_pkg;

    // Sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACK_LOW = 3'd1,
        ACK_GAP = 3'd2,
        DELIVER = 3'd3,
        RECOVER = 3'd4
    } state_t;

    // First byte the controller must return in MCS-80/85 mode (CALL opcode).
    localparam logic [7:0] INTA_CALL_OPCODE = 8'hCD;

    // Values of mcs80_mode.
    localparam logic MODE_8086  = 1'b0;
    localparam logic MODE_MCS80 = 1'b1;

    // Index of the final INTA pulse for a given mode (2 or 3 pulses total).
    function automatic logic [1:0] last_pulse_index(input logic mode);
        return (mode == MODE_MCS80) ? 2'd2 : 2'd1;
    endfunction

endpackage

// File: rtl/intack_pulse_timer.sv
// Four-bit down counter timing INTA low phases, gaps and recovery.
// done is high while the count is zero; the counter never wraps.
module intack_pulse_timer (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_value,
    input  logic       count,
    output logic       done
);

    logic [3:0] count_reg;

    // Load takes priority; otherwise count down and stop at zero.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= 4'd0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count && (count_reg != 4'd0)) begin
            count_reg <= count_reg - 4'd1;
        end
    end

    assign done = (count_reg == 4'd0);

endmodule

// File: rtl/intack_sequencer.sv
// CPU-side INTA pulse train generator for an 8259A-compatible controller.
// Issues two (8086) or three (MCS-80/85) INTA pulses, captures the bus
// bytes and presents the assembled vector over a valid/ready handshake.
module intack_sequencer
    import intack_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        interrupt_request,
    input  logic        interrupt_enable,
    input  logic        mcs80_mode,
    input  logic [7:0]  data_bus_in,
    output logic        interrupt_acknowledge_n,
    output logic        busy,
    output logic        vector_valid,
    input  logic        vector_ready,
    output logic [7:0]  vector_type,
    output logic [15:0] call_address,
    output logic        protocol_error
);

    // The timer is four bits wide, so each phase length must fit 1..15.
    generate
        if ((INTA_LOW_CYCLES < 1) || (INTA_LOW_CYCLES > 15)) begin : g_bad_low
            $error("INTA_LOW_CYCLES must be in 1..15");
        end
        if ((INTA_GAP_CYCLES < 1) || (INTA_GAP_CYCLES > 15)) begin : g_bad_gap
            $error("INTA_GAP_CYCLES must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] LOW_LOAD = 4'(INTA_LOW_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD = 4'(INTA_GAP_CYCLES - 1);

    state_t      state_reg, state_next;
    logic [1:0]  pulse_idx_reg, pulse_idx_next;
    logic        mode_reg, mode_next;

    logic        timer_load;
    logic [3:0]  timer_value;
    logic        timer_count;
    logic        timer_done;

    logic        capture;
    logic        deliver;
    logic        start_request;

    logic [7:0]  byte_reg [0:1];

    logic        inta_n_reg;
    logic        busy_reg;
    logic        valid_reg;
    logic [7:0]  vector_type_reg;
    logic [15:0] call_address_reg;
    logic        protocol_error_reg;

    assign start_request = interrupt_request && interrupt_enable;
    assign timer_count   = (state_reg == ACK_LOW) || (state_reg == ACK_GAP) ||
                           (state_reg == RECOVER);

    intack_pulse_timer u_timer (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .count      (timer_count),
        .done       (timer_done)
    );

    // State, pulse index and latched mode registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            pulse_idx_reg <= 2'd0;
            mode_reg      <= MODE_8086;
        end else begin
            state_reg     <= state_next;
            pulse_idx_reg <= pulse_idx_next;
            mode_reg      <= mode_next;
        end
    end

    // Next-state logic and timer control.
    always_comb begin
        state_next     = state_reg;
        pulse_idx_next = pulse_idx_reg;
        mode_next      = mode_reg;
        timer_load     = 1'b0;
        timer_value    = LOW_LOAD;
        capture        = 1'b0;
        deliver        = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_request) begin
                    state_next     = ACK_LOW;
                    pulse_idx_next = 2'd0;
                    mode_next      = mcs80_mode;
                    timer_load     = 1'b1;
                    timer_value    = LOW_LOAD;
                end
            end

            ACK_LOW: begin
                if (timer_done) begin
                    capture = 1'b1;
                    if (pulse_idx_reg == last_pulse_index(mode_reg)) begin
                        state_next = DELIVER;
                        deliver    = 1'b1;
                    end else begin
                        state_next  = ACK_GAP;
                        timer_load  = 1'b1;
                        timer_value = GAP_LOAD;
                    end
                end
            end

            ACK_GAP: begin
                if (timer_done) begin
                    state_next     = ACK_LOW;
                    pulse_idx_next = pulse_idx_reg + 2'd1;
                    timer_load     = 1'b1;
                    timer_value    = LOW_LOAD;
                end
            end

            DELIVER: begin
                if (vector_ready) begin
                    state_next  = RECOVER;
                    timer_load  = 1'b1;
                    timer_value = GAP_LOAD;
                end
            end

            RECOVER: begin
                // The edge that ends the recovery gap may itself be the next
                // start edge, so a held request restarts exactly one gap after
                // the accepting edge.
                if (timer_done) begin
                    if (start_request) begin
                        state_next     = ACK_LOW;
                        pulse_idx_next = 2'd0;
                        mode_next      = mcs80_mode;
                        timer_load     = 1'b1;
                        timer_value    = LOW_LOAD;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Capture the non-final bus bytes; the final byte is consumed directly.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            byte_reg[0] <= 8'h00;
            byte_reg[1] <= 8'h00;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (capture && (pulse_idx_reg == 2'(i))) begin
                    byte_reg[i] <= data_bus_in;
                end
            end
        end
    end

    // Registered pin and handshake outputs, derived from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inta_n_reg <= 1'b1;
            busy_reg   <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            inta_n_reg <= (state_next != ACK_LOW);
            busy_reg   <= (state_next != IDLE);
            valid_reg  <= (state_next == DELIVER);
        end
    end

    // Assemble the result on the last sample edge; it holds until the next one.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vector_type_reg    <= 8'h00;
            call_address_reg   <= 16'h0000;
            protocol_error_reg <= 1'b0;
        end else if (deliver) begin
            if (mode_reg == MODE_MCS80) begin
                vector_type_reg    <= 8'h00;
                call_address_reg   <= {data_bus_in, byte_reg[1]};
                protocol_error_reg <= (byte_reg[0] != INTA_CALL_OPCODE);
            end else begin
                vector_type_reg    <= data_bus_in;
                call_address_reg   <= 16'h0000;
                protocol_error_reg <= 1'b0;
            end
        end
    end

    assign interrupt_acknowledge_n = inta_n_reg;
    assign busy                    = busy_reg;
    assign vector_valid            = valid_reg;
    assign vector_type             = vector_type_reg;
    assign call_address            = call_address_reg;
    assign protocol_error          = protocol_error_reg;

endmodule
